calc_op_sequencer: RTL and testbench
====================================

Name: calc_op_sequencer

Overview:
- Initiator/front end for the combinational 4-bit calculator datapath (operands A/B, 2-bit function, 8-bit result).
- Accepts operand, function and execute commands over a valid/ready command port and drives stable operands and function into the calculator.
- After a programmable settle time, captures the calculator's 8-bit result and returns it over a valid/ready result port, with divide-by-zero flagged.

Parameters:
- SETTLE_CYCLES, 2, cycles calc_* are held stable before calc_result is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer accepts a command this cycle.
- cmd_op  input  2  00 LOAD_A, 01 LOAD_B, 10 LOAD_FN, 11 EXEC.
- cmd_data  input  4  operand value (LOAD_A/LOAD_B); [1:0] = function code for LOAD_FN; ignored for EXEC.
- calc_a  output  4  operand A to calculator.
- calc_b  output  4  operand B to calculator.
- calc_fn  output  2  function to calculator: 00 add, 01 sub, 10 mul, 11 div.
- calc_result  input  8  combinational result from calculator.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  8  captured result.
- res_err  output  1  divide-by-zero flag, qualified by res_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, calc_a=0, calc_b=0, calc_fn=00, res_valid=0, res_data=0, res_err=0, settle counter=0. cmd_ready is driven by state, so it is 1 after reset.
- States: IDLE, SETTLE, HOLD.
- cmd_ready = (state==IDLE). A command is accepted when cmd_valid && cmd_ready.
- IDLE:
  - LOAD_A: calc_a<=cmd_data.
  - LOAD_B: calc_b<=cmd_data.
  - LOAD_FN: calc_fn<=cmd_data[1:0].
  - LOAD_* commands stay in IDLE. One command is accepted per cycle, and loaded values are visible on calc_* the next cycle.
- EXEC with calc_fn==11 and calc_b==0: skip SETTLE; res_data<=8'hFF, res_err<=1, res_valid<=1; go to HOLD.
- EXEC otherwise: counter<=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - calc_a, calc_b and calc_fn are frozen.
  - If counter!=0, decrement it.
  - If counter==0, res_data<=calc_result, res_err<=0, res_valid<=1; go to HOLD.
  - Latency from the EXEC accept edge to res_valid high is SETTLE_CYCLES+1 cycles. With the default of 2, that is 3 cycles.
- HOLD:
  - res_valid, res_data and res_err are held stable until res_ready=1.
  - On res_valid && res_ready: res_valid<=0; go to IDLE.
  - res_err stays at its last value but is meaningless while res_valid=0.
- cmd_ready is low in SETTLE and HOLD. A command presented in the same cycle as the result handshake is not accepted; it is accepted at the earliest on the next cycle (IDLE).
- The result is passed through unchanged. Sub is the 8-bit two's-complement difference of zero-extended operands (3-5 = 8'hFE). Mul max is 8'hE1. Div is an unsigned integer quotient.
- Operand registers persist across EXECs. Repeated EXEC without new loads recomputes with the same operands.
- rst asserted in SETTLE or HOLD aborts the operation: no result is delivered, and all outputs take their reset values on the next edge.

Optional Feature:
- Macro: CALC_SEQ_CHAIN_EN.
- Defined: on every result capture (including divide-by-zero), calc_a<=captured value [3:0] in the same edge, so the next EXEC chains on the previous result. A LOAD_A issued afterwards overrides it.
- Not defined: calc_a changes only via LOAD_A or rst.

Test Plan:
- LOAD_A 3, LOAD_B 5, LOAD_FN 00, EXEC, res_ready=1 -> res_valid exactly 3 cycles after EXEC accept, res_data=8'h08, res_err=0, busy low the cycle after the handshake.
- A=3, B=5, FN=01, EXEC -> res_data=8'hFE. Then A=15, B=15, FN=10, EXEC -> res_data=8'hE1.
- A=9, B=0, FN=11, EXEC -> res_valid 1 cycle after accept, res_data=8'hFF, res_err=1. Then B=2, EXEC -> res_data=8'h04, res_err=0.
- Backpressure: hold res_ready=0 for 5 cycles in HOLD with cmd_valid=1 (LOAD_A 7) -> res_data stable, cmd_ready=0, calc_a unchanged. Raise res_ready -> LOAD_A is accepted the cycle after the handshake.
- Assert rst in the 2nd SETTLE cycle -> no res_valid ever; all outputs at reset values next cycle; cmd_ready=1.
- CALC_SEQ_CHAIN_EN: A=2, B=3, FN=10, EXEC -> result 8'h06 and calc_a=6; EXEC again -> result 8'h12. Without the macro the second EXEC -> 8'h06.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// Command front end for the 4-bit calculator: loads operands/function, runs EXEC with a settle delay, returns the result.
// Optional: define CALC_SEQ_CHAIN_EN to feed each captured result[3:0] back into operand A.
module calc_op_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] calc_a,
  output logic [3:0] calc_b,
  output logic [1:0] calc_fn,
  input  logic [7:0] calc_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic       busy
);

`ifdef CALC_SEQ_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  localparam logic [1:0] OP_LOAD_A  = 2'b00;
  localparam logic [1:0] OP_LOAD_B  = 2'b01;
  localparam logic [1:0] OP_LOAD_FN = 2'b10;
  localparam logic [1:0] OP_EXEC    = 2'b11;
  localparam logic [1:0] FN_DIV     = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] fn_q, fn_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_err_q, res_err_d;
  logic       res_valid_q, res_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= 4'h0;
      b_q         <= 4'h0;
      fn_q        <= 2'b00;
      cnt_q       <= 4'h0;
      res_data_q  <= 8'h00;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fn_q        <= fn_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fn_d        = fn_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    cmd_ready   = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD_A:  a_d  = cmd_data;
            OP_LOAD_B:  b_d  = cmd_data;
            OP_LOAD_FN: fn_d = cmd_data[1:0];
            OP_EXEC: begin
              // Divide by zero never goes through the calculator; report it immediately.
              if (fn_q == FN_DIV && b_q == 4'h0) begin
                res_data_d  = 8'hFF;
                res_err_d   = 1'b1;
                res_valid_d = 1'b1;
                if (CHAIN_EN) a_d = 4'hF;
                state_d     = HOLD;
              end else begin
                cnt_d   = CNT_INIT;
                state_d = SETTLE;
              end
            end
            default: ;
          endcase
        end
      end
      SETTLE: begin
        if (cnt_q != 4'h0) begin
          cnt_d = cnt_q - 4'h1;
        end else begin
          res_data_d  = calc_result;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          if (CHAIN_EN) a_d = calc_result[3:0];
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign calc_a    = a_q;
  assign calc_b    = b_q;
  assign calc_fn   = fn_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed test-plan cases plus randomized load/exec traffic against a behavioural model.
module tb_calc_op_sequencer;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] calc_a;
  logic [3:0] calc_b;
  logic [1:0] calc_fn;
  logic [7:0] calc_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic       busy;

  int n_checks = 0;
  int n_errs   = 0;
  int ma, mb, mf;

  always #5 clk = ~clk;

  calc_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .calc_a(calc_a), .calc_b(calc_b),
    .calc_fn(calc_fn), .calc_result(calc_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  // Stand-in for the external combinational calculator (outputs junk on divide by zero).
  always_comb begin
    case (calc_fn)
      2'b00:   calc_result = {4'h0, calc_a} + {4'h0, calc_b};
      2'b01:   calc_result = {4'h0, calc_a} - {4'h0, calc_b};
      2'b10:   calc_result = {4'h0, calc_a} * {4'h0, calc_b};
      default: calc_result = (calc_b == 4'h0) ? 8'h00 : {4'h0, calc_a / calc_b};
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_res(input int a, input int b, input int f);
    case (f)
      0:       return (a + b) & 255;
      1:       return (a - b) & 255;
      2:       return a * b;
      default: return (b == 0) ? 255 : a / b;
    endcase
  endfunction

  // Presents a command and returns just after the edge that accepts it.
  task automatic issue(input logic [1:0] op, input logic [3:0] d);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("issue_ready_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic load(input int op, input int d);
    issue(2'(op), 4'(d));
    case (op)
      0: begin ma = d;     check("load_a", int'(calc_a), ma); end
      1: begin mb = d;     check("load_b", int'(calc_b), mb); end
      default: begin mf = d & 3; check("load_fn", int'(calc_fn), mf); end
    endcase
    check("load_ready", int'(cmd_ready), 1);
  endtask

  task automatic exec_check(input int hold_cycles, input bit bp_load, output int got_res);
    int  e    = exp_res(ma, mb, mf);
    bit  eerr = (mf == 3 && mb == 0);
    int  elat = eerr ? 1 : SETTLE + 1;
    int  lat  = 1;
    issue(2'b11, 4'h0);
    check("exec_busy", int'(busy), 1);
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    got_res = int'(res_data);
    check("exec_latency", lat, elat);
    check("exec_data", int'(res_data), e);
    check("exec_err", int'(res_err), int'(eerr));
`ifdef CALC_SEQ_CHAIN_EN
    ma = e & 15;
`endif
    check("exec_chain_a", int'(calc_a), ma);
    if (bp_load) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_data  = 4'h7;
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", int'(res_valid), 1);
      check("hold_data", int'(res_data), e);
      check("hold_err", int'(res_err), int'(eerr));
      check("hold_ready", int'(cmd_ready), 0);
      check("hold_a", int'(calc_a), ma);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check("hs_valid", int'(res_valid), 0);
    check("hs_busy", int'(busy), 0);
    check("hs_ready", int'(cmd_ready), 1);
    check("hs_a_not_loaded", int'(calc_a), ma);
    if (bp_load) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      ma = 7;
      check("bp_load_a", int'(calc_a), ma);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, int'(cmd_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_valid"}, int'(res_valid), 0);
    check({tag, "_data"}, int'(res_data), 0);
    check({tag, "_err"}, int'(res_err), 0);
    check({tag, "_abf"}, {24'h0, calc_a, calc_b}, 0);
    check({tag, "_fn"}, int'(calc_fn), 0);
  endtask

  initial begin
    int r;
    int r1;
    bit saw_valid;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0; res_ready = 1'b0;
    ma = 0; mb = 0; mf = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Add, sub, mul directed cases.
    load(0, 3); load(1, 5); load(2, 0);
    exec_check(0, 0, r); check("add_3_5", r, 8'h08);
    load(0, 3); load(1, 5); load(2, 1);
    exec_check(1, 0, r); check("sub_3_5", r, 8'hFE);
    load(0, 15); load(1, 15); load(2, 2);
    exec_check(0, 0, r); check("mul_15_15", r, 8'hE1);

    // Divide by zero, then a normal divide.
    load(0, 9); load(1, 0); load(2, 3);
    exec_check(0, 0, r); check("div_by_zero", r, 8'hFF);
    load(1, 2);
    exec_check(0, 0, r);
`ifndef CALC_SEQ_CHAIN_EN
    check("div_9_2", r, 8'h04);
`endif

    // Backpressure with a pending LOAD_A 7.
    load(0, 4); load(1, 1); load(2, 0);
    exec_check(5, 1, r); check("bp_add", r, 8'h05);

    // Reset during the second SETTLE cycle aborts the operation.
    load(0, 3); load(1, 5); load(2, 0);
    issue(2'b11, 4'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ma = 0; mb = 0; mf = 0;
    check_reset_state("abort");
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (res_valid) saw_valid = 1'b1;
    end
    check("abort_no_result", int'(saw_valid), 0);

    // Chaining (or not) on repeated EXEC.
    load(0, 2); load(1, 3); load(2, 2);
    exec_check(0, 0, r); check("chain_first", r, 8'h06);
    exec_check(0, 0, r1);
`ifdef CALC_SEQ_CHAIN_EN
    check("chain_second", r1, 8'h12);
`else
    check("chain_second", r1, 8'h06);
`endif

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          int op = $urandom_range(0, 2);
          int d  = $urandom_range(0, 15);
          if (op == 1 && $urandom_range(0, 3) == 0) d = 0;
          load(op, d);
        end
      end
      exec_check($urandom_range(0, 3), ($urandom_range(0, 3) == 0), r);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errs);
    $fatal(1);
  end
endmodule
